// File: rtl/instr_stream_loader.sv
// instr_stream_loader
// Upstream feeder for the instruction FIFO. Packs a valid/ready byte stream
// big-endian into 32-bit words, buffers them in a small skid queue and writes
// them one per pulse into the FIFO, throttled by the FIFO's AFULL/FULL flags.
//
// Ports:
//   clkHI       single clock, rising edge
//   rst         asynchronous active-low reset
//   start       arms a load (honoured only in IDLE or DONE)
//   in_valid    byte stream valid
//   in_ready    byte stream ready (ASSEMBLE and queue not full)
//   in_data     byte payload
//   in_last     final byte of the program
//   fifo_afull  FIFO almost full
//   fifo_full   FIFO full
//   valid_out   one-cycle write strobe into the FIFO
//   wr_data     word written into the FIFO, held between strobes
//   busy        high in ASSEMBLE and DRAIN
//   done        high in DONE
//   word_count  words delivered since the last accepted start (saturating)
//   checksum    XOR of issued words since start (only with LOADER_CHECKSUM_EN)
//
// Optional feature macro: LOADER_CHECKSUM_EN

module instr_stream_loader #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clkHI,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               fifo_afull,
    input  logic               fifo_full,
    output logic               valid_out,
    output logic [31:0]        wr_data,
    output logic               busy,
    output logic               done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]        checksum,
`endif
    output logic [COUNT_W-1:0] word_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ASSEMBLE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      queue_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic [1:0]       byte_idx;
    logic [31:0]      asm_word;
    logic [31:0]      merged_word;

    logic accept, push, pop, start_ok;

    // Handshake and queue control. The incoming byte is dropped into its
    // big-endian lane: index 0 lands in [31:24], so the shift is (3-idx)*8.
    always_comb begin
        in_ready    = (state == ASSEMBLE) && (q_count < CNT_W'(DEPTH));
        accept      = in_valid && in_ready;
        push        = accept && ((byte_idx == 2'd3) || in_last);
        pop         = (q_count != '0) && !fifo_afull && !fifo_full;
        start_ok    = start && ((state == IDLE) || (state == DONE));
        merged_word = asm_word | ({24'd0, in_data} << {~byte_idx, 3'b000});
    end

    // Next-state logic; busy/done decode straight from the registered state.
    always_comb begin
        state_nxt = state;
        busy      = (state == ASSEMBLE) || (state == DRAIN);
        done      = (state == DONE);
        case (state)
            IDLE:     if (start) state_nxt = ASSEMBLE;
            ASSEMBLE: if (accept && in_last) state_nxt = DRAIN;
            DRAIN:    if ((q_count == '0) && !valid_out) state_nxt = DONE;
            DONE:     if (start) state_nxt = ASSEMBLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Partial word assembly. Low bytes stay zero, which gives the zero pad
    // when in_last arrives before the word is full.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst) begin
            asm_word <= '0;
            byte_idx <= '0;
        end else if (start_ok || push) begin
            asm_word <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            asm_word <= merged_word;
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Queue storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clkHI) begin
        if (push) queue_mem[wr_ptr] <= merged_word;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // FIFO write port: a pop this cycle becomes a one-cycle strobe next cycle.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            wr_data   <= '0;
        end else begin
            valid_out <= pop;
            if (pop) wr_data <= queue_mem[rd_ptr];
        end
    end

    // Delivered-word counter, saturating at all ones.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst)                                 word_count <= '0;
        else if (start_ok)                        word_count <= '0;
        else if (valid_out && (word_count != '1)) word_count <= word_count + COUNT_W'(1);
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every word actually strobed into the FIFO.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst)           checksum <= '0;
        else if (start_ok)  checksum <= '0;
        else if (valid_out) checksum <= checksum ^ wr_data;
    end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader
// Scoreboard bench for instr_stream_loader: a byte-level packing model pushes
// expected words when bytes are accepted, and a negedge monitor pops and
// compares them whenever valid_out is seen.

module tb_instr_stream_loader;

    logic        clkHI = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        fifo_afull;
    logic        fifo_full;
    logic        valid_out;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [7:0]  tx_bytes[$];
    int          tx_idx;
    logic [31:0] exp_q[$];
    logic [31:0] model_word;
    int          model_idx;
    logic [31:0] model_xor;
    logic [31:0] last_wr;

    instr_stream_loader #(.DEPTH(4), .COUNT_W(16)) dut (
        .clkHI      (clkHI),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .fifo_afull (fifo_afull),
        .fifo_full  (fifo_full),
        .valid_out  (valid_out),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
`ifdef LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .word_count (word_count)
    );

    always #5 clkHI = ~clkHI;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Packing model: big-endian lanes, zero pad on in_last.
    task automatic model_accept(input logic [7:0] data, input logic last);
        model_word = model_word | (32'(data) << (8 * (3 - model_idx)));
        if (model_idx == 3 || last) begin
            exp_q.push_back(model_word);
            model_xor  = model_xor ^ model_word;
            model_word = '0;
            model_idx  = 0;
        end else begin
            model_idx++;
        end
    endtask

    task automatic model_clear();
        model_word = '0;
        model_idx  = 0;
        model_xor  = '0;
        exp_q.delete();
    endtask

    // Drives tx_bytes from tx_idx for at most max_cycles; in_last on the final byte.
    task automatic applyStimulus(input int max_cycles);
        logic acc;
        for (int c = 0; c < max_cycles && tx_idx < tx_bytes.size(); c++) begin
            in_valid = 1'b1;
            in_data  = tx_bytes[tx_idx];
            in_last  = (tx_idx == tx_bytes.size() - 1);
            @(negedge clkHI);
            acc = in_ready;
            @(posedge clkHI);
            #1;
            if (acc) begin
                model_accept(in_data, in_last);
                tx_idx++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_start();
        model_clear();
        start = 1'b1;
        @(posedge clkHI);
        #1;
        start  = 1'b0;
        pulses = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clkHI);
            if (done) break;
        end
        checkOutput("done_reached", 32'(done), 32'd1);
        @(posedge clkHI);
        #1;
    endtask

    // Monitor: compare each strobe against the scoreboard; between strobes
    // wr_data must hold the last expected word.
    always @(negedge clkHI) begin
        if (!rst) begin
            last_wr = '0;
        end else if (valid_out) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                last_wr = exp_q.pop_front();
                checkOutput("wr_data", wr_data, last_wr);
            end
        end else begin
            checkOutput("wr_hold", wr_data, last_wr);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        fifo_afull = 1'b0;
        fifo_full  = 1'b0;
        tx_idx     = 0;
        model_clear();

        repeat (2) @(negedge clkHI);
        checkOutput("rst_in_ready",   32'(in_ready),   32'd0);
        checkOutput("rst_valid_out",  32'(valid_out),  32'd0);
        checkOutput("rst_wr_data",    wr_data,         32'd0);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_done",       32'(done),       32'd0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);
        @(posedge clkHI);
        #1;
        rst = 1'b1;
        @(posedge clkHI);
        #1;

        // T1: two full words, no stall.
        $display("[TB] T1 basic packing");
        pulse_start();
        checkOutput("t1_busy_start", 32'(busy), 32'd1);
        tx_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        tx_idx   = 0;
        applyStimulus(50);
        wait_done();
        checkOutput("t1_pulses",     32'(pulses),       32'd2);
        checkOutput("t1_word_count", 32'(word_count),   32'd2);
        checkOutput("t1_busy",       32'(busy),         32'd0);
        checkOutput("t1_sb_empty",   32'(exp_q.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("t6_checksum", checksum, model_xor);
        checkOutput("t6_checksum_const", checksum, 32'h88888888);
`endif

        // T2: six bytes, second word zero padded.
        $display("[TB] T2 zero pad");
        pulse_start();
`ifdef LOADER_CHECKSUM_EN
        checkOutput("t6_checksum_clr", checksum, 32'd0);
`endif
        checkOutput("t2_count_clr", 32'(word_count), 32'd0);
        tx_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        tx_idx   = 0;
        applyStimulus(50);
        checkOutput("t2_pad_model", exp_q.size() > 0 ? exp_q[exp_q.size()-1] : 32'd0, 32'hEEFF0000);
        wait_done();
        checkOutput("t2_word_count", 32'(word_count), 32'd2);
        checkOutput("t2_pulses",     32'(pulses),     32'd2);

        // T3: afull held; queue fills at 16 bytes, then drains 5 words.
        $display("[TB] T3 afull back-pressure");
        fifo_afull = 1'b1;
        pulse_start();
        tx_bytes.delete();
        for (int i = 0; i < 20; i++) tx_bytes.push_back(8'(i + 1));
        tx_idx = 0;
        applyStimulus(40);
        checkOutput("t3_accepted", 32'(tx_idx),   32'd16);
        checkOutput("t3_no_pulse", 32'(pulses),   32'd0);
        checkOutput("t3_in_ready", 32'(in_ready), 32'd0);
        fifo_afull = 1'b0;
        applyStimulus(200);
        checkOutput("t3_all_sent", 32'(tx_idx), 32'd20);
        wait_done();
        checkOutput("t3_pulses",     32'(pulses),       32'd5);
        checkOutput("t3_word_count", 32'(word_count),   32'd5);
        checkOutput("t3_sb_empty",   32'(exp_q.size()), 32'd0);

        // T4: one-cycle full pulse during drain skips exactly one pop.
        $display("[TB] T4 full stall");
        fifo_afull = 1'b1;
        pulse_start();
        tx_bytes.delete();
        for (int i = 0; i < 12; i++) tx_bytes.push_back(8'(i * 8'h11));
        tx_idx = 0;
        applyStimulus(40);
        checkOutput("t4_accepted", 32'(tx_idx), 32'd12);
        fifo_afull = 1'b0;
        @(posedge clkHI);
        #1;
        checkOutput("t4_first", 32'(valid_out), 32'd1);
        fifo_full = 1'b1;
        @(posedge clkHI);
        #1;
        checkOutput("t4_gap",      32'(valid_out), 32'd0);
        checkOutput("t4_gap_data", wr_data,        32'h00112233);
        fifo_full = 1'b0;
        wait_done();
        checkOutput("t4_pulses",     32'(pulses),     32'd3);
        checkOutput("t4_word_count", 32'(word_count), 32'd3);

        // T5: reset mid-word discards the partial word.
        $display("[TB] T5 reset mid-word");
        pulse_start();
        tx_bytes = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
        tx_idx   = 0;
        applyStimulus(2);
        checkOutput("t5_partial", 32'(tx_idx), 32'd2);
        rst = 1'b0;
        #2;
        checkOutput("t5_in_ready",   32'(in_ready),   32'd0);
        checkOutput("t5_valid_out",  32'(valid_out),  32'd0);
        checkOutput("t5_wr_data",    wr_data,         32'd0);
        checkOutput("t5_busy",       32'(busy),       32'd0);
        checkOutput("t5_done",       32'(done),       32'd0);
        checkOutput("t5_word_count", 32'(word_count), 32'd0);
        model_clear();
        @(posedge clkHI);
        #1;
        rst = 1'b1;
        @(posedge clkHI);
        #1;
        pulse_start();
        tx_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        tx_idx   = 0;
        applyStimulus(20);
        wait_done();
        checkOutput("t5_pulses",     32'(pulses),     32'd1);
        checkOutput("t5_word_count", 32'(word_count), 32'd1);
        checkOutput("t5_last_word",  wr_data,         32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
